// File: rtl/dp_step_controller.sv
// Datapath clock-enable sequencer: turns switch/button/halt inputs into a
// single-cycle Tick enable so the whole datapath stays on Clk.
module dp_step_controller #(
    parameter int TICK_PERIOD = 100000000,
    parameter int CNT_W       = 27,
    parameter int DBNC_CYCLES = 1000000,
    parameter int DBNC_W      = 20
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RunSw,
    input  logic        StepBtn,
    input  logic        HaltReq,
    output logic        Tick,
    output logic        Running,
    output logic        Halted,
    output logic [15:0] StepCnt
);

    // state | meaning
    // IDLE  | waiting; a debounced press issues one Tick
    // RUN   | free-run, one Tick every TICK_PERIOD cycles
    // HALT  | datapath asked to stop; only Rst leaves
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  RATE_LAST = CNT_W'(TICK_PERIOD - 1);
    localparam logic [DBNC_W-1:0] DBNC_LAST = DBNC_W'(DBNC_CYCLES - 1);

    logic              r_run_s1;
    logic              r_run_s2;
    logic              r_btn_s1;
    logic              r_btn_s2;
    logic              r_db;
    logic              r_db_q;
    logic              r_step_req;
    logic [DBNC_W-1:0] r_dbnc_cnt;

    state_t            r_state;
    logic [CNT_W-1:0]  r_rate_cnt;
    logic              r_tick;
    logic              r_running;
    logic              r_halted;
    logic [15:0]       r_step_cnt;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_rate_nxt;
    logic              w_tick_nxt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_run_s1   <= 1'b0;
            r_run_s2   <= 1'b0;
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_db       <= 1'b0;
            r_db_q     <= 1'b0;
            r_step_req <= 1'b0;
            r_dbnc_cnt <= '0;
        end else begin
            r_run_s1 <= RunSw;
            r_run_s2 <= r_run_s1;
            r_btn_s1 <= StepBtn;
            r_btn_s2 <= r_btn_s1;
            // Accept a new button level only after it has held for the full window.
            if (r_btn_s2 == r_db) begin
                r_dbnc_cnt <= '0;
            end else if (r_dbnc_cnt == DBNC_LAST) begin
                r_db       <= r_btn_s2;
                r_dbnc_cnt <= '0;
            end else begin
                r_dbnc_cnt <= r_dbnc_cnt + DBNC_W'(1);
            end
            r_db_q     <= r_db;
            r_step_req <= r_db & ~r_db_q;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rate_nxt  = '0;
        w_tick_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (HaltReq) begin
                    w_state_nxt = ST_HALT;
                end else if (r_run_s2) begin
                    w_state_nxt = ST_RUN;
                end else if (r_step_req) begin
                    w_tick_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                // Halt and switch-off both drop whatever Tick was due this cycle.
                if (HaltReq) begin
                    w_state_nxt = ST_HALT;
                end else if (!r_run_s2) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_rate_cnt == RATE_LAST) begin
                    w_tick_nxt = 1'b1;
                end else begin
                    w_rate_nxt = r_rate_cnt + CNT_W'(1);
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_rate_cnt <= '0;
            r_tick     <= 1'b0;
            r_running  <= 1'b0;
            r_halted   <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rate_cnt <= w_rate_nxt;
            r_tick     <= w_tick_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_halted   <= (w_state_nxt == ST_HALT);
            if (w_tick_nxt && (r_step_cnt != 16'hFFFF)) begin
                r_step_cnt <= r_step_cnt + 16'd1;
            end
        end
    end

    assign Tick    = r_tick;
    assign Running = r_running;
    assign Halted  = r_halted;
    assign StepCnt = r_step_cnt;

endmodule

// File: tb/tb_dp_step_controller.sv
// Scoreboard bench: two instances (TICK_PERIOD 10 and 1) share stimulus; a
// timing-level reference model queues expected outputs for every edge.
module tb_dp_step_controller;

    localparam int TP_A  = 10;
    localparam int TP_B  = 1;
    localparam int DB    = 4;
    localparam int MAXN  = 131072;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        RunSw = 1'b0;
    logic        StepBtn = 1'b0;
    logic        HaltReq = 1'b0;
    logic        Tick_a, Running_a, Halted_a;
    logic        Tick_b, Running_b, Halted_b;
    logic [15:0] StepCnt_a, StepCnt_b;

    typedef struct packed {
        logic        tick;
        logic        running;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;
    int   n = 0;
    int   mon_edge = 0;

    bit   h_run[MAXN];
    bit   h_btn[MAXN];
    int   last_rst = -1000;
    bit   m_db = 1'b0;
    int   m_rise = -100;
    int   m_mode[2];
    int   m_start[2];
    int   m_cnt[2];
    int   m_tp[2];

    dp_step_controller #(.TICK_PERIOD(TP_A), .CNT_W(27), .DBNC_CYCLES(DB), .DBNC_W(20)) u_dut_a (
        .Clk(Clk), .Rst(Rst), .RunSw(RunSw), .StepBtn(StepBtn), .HaltReq(HaltReq),
        .Tick(Tick_a), .Running(Running_a), .Halted(Halted_a), .StepCnt(StepCnt_a)
    );

    dp_step_controller #(.TICK_PERIOD(TP_B), .CNT_W(27), .DBNC_CYCLES(DB), .DBNC_W(20)) u_dut_b (
        .Clk(Clk), .Rst(Rst), .RunSw(RunSw), .StepBtn(StepBtn), .HaltReq(HaltReq),
        .Tick(Tick_b), .Running(Running_b), .Halted(Halted_b), .StepCnt(StepCnt_b)
    );

    always #5 Clk = ~Clk;

    // Value the controller sees at edge e: the raw input from two edges earlier,
    // unless a reset at either of the two synchronizer edges cleared it.
    function automatic bit sync_of(input bit is_btn, input int e);
        int s;
        s = e - 2;
        if (s < 0 || s <= last_rst) return 1'b0;
        return is_btn ? h_btn[s] : h_run[s];
    endfunction

    task automatic model_edge(input bit rst, input bit halt);
        exp_t e;
        bit   all_diff;
        bit   step;
        bit   run;
        bit   tick;
        if (rst) begin
            last_rst = n;
            m_db = 1'b0;
            m_rise = -100;
            for (int d = 0; d < 2; d++) begin
                m_mode[d] = M_IDLE;
                m_cnt[d] = 0;
            end
            e = '0;
            q_a.push_back(e);
            q_b.push_back(e);
            return;
        end
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) begin
            if ((n - k) <= last_rst || sync_of(1'b1, n - k) == m_db) all_diff = 1'b0;
        end
        step = (m_rise == n - 2);
        if (all_diff) begin
            m_db = !m_db;
            if (m_db) m_rise = n;
        end
        run = sync_of(1'b0, n);
        for (int d = 0; d < 2; d++) begin
            tick = 1'b0;
            case (m_mode[d])
                M_IDLE: begin
                    if (halt) m_mode[d] = M_HALT;
                    else if (run) begin
                        m_mode[d] = M_RUN;
                        m_start[d] = n;
                    end else if (step) tick = 1'b1;
                end
                M_RUN: begin
                    if (halt) m_mode[d] = M_HALT;
                    else if (!run) m_mode[d] = M_IDLE;
                    else tick = (((n - m_start[d]) % m_tp[d]) == 0);
                end
                default: ;
            endcase
            if (tick && m_cnt[d] < 65535) m_cnt[d]++;
            e.tick = tick;
            e.running = (m_mode[d] == M_RUN);
            e.halted = (m_mode[d] == M_HALT);
            e.cnt = 16'(m_cnt[d]);
            if (d == 0) q_a.push_back(e);
            else q_b.push_back(e);
        end
    endtask

    task automatic cyc(input bit rst, input bit run, input bit btn, input bit halt);
        @(negedge Clk);
        Rst = rst;
        RunSw = run;
        StepBtn = btn;
        HaltReq = halt;
        n++;
        h_run[n] = run;
        h_btn[n] = btn;
        model_edge(rst, halt);
        armed = 1'b1;
    endtask

    task automatic cmp(input int d, input exp_t act);
        exp_t e;
        if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
            errors++;
            $display("FAIL scoreboard_empty dut%0d edge %0d: no expected entry", d, mon_edge);
            return;
        end
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        checks++;
        if (act !== e) begin
            errors++;
            if (errors <= 30)
                $display("FAIL outputs dut%0d edge %0d: got tick=%b run=%b halt=%b cnt=%h, want tick=%b run=%b halt=%b cnt=%h",
                         d, mon_edge, act.tick, act.running, act.halted, act.cnt,
                         e.tick, e.running, e.halted, e.cnt);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        if (armed) begin
            mon_edge++;
            cmp(0, {Tick_a, Running_a, Halted_a, StepCnt_a});
            cmp(1, {Tick_b, Running_b, Halted_b, StepCnt_b});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lvl;
        bit run_lvl;
        int bl;
        int i;
        m_tp[0] = TP_A;
        m_tp[1] = TP_B;
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_IDLE;
            m_start[d] = 0;
            m_cnt[d] = 0;
        end

        // Reset with random inputs
        repeat (3) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Free-run then switch off
        repeat (105) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (15) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Bouncy press, bouncy release, then a clean press
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Halt exactly when the first RUN Tick is due, then ignore everything
        i = 0;
        while (i < 60 && !(m_mode[0] == M_RUN && (n + 1 - m_start[0]) == TP_A)) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            i++;
        end
        checks++;
        if (i >= 60) begin
            errors++;
            $display("FAIL halt_setup: run phase not reached within %0d cycles", i);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (40) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (10) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset pulse mid-run with the counter at 7
        i = 0;
        while (i < 60 && !(m_mode[0] == M_RUN && (n + 1 - m_start[0]) == 8)) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            i++;
        end
        checks++;
        if (i >= 60) begin
            errors++;
            $display("FAIL reset_setup: run phase not reached within %0d cycles", i);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Random operation with bouncy presses, rare halts and resets
        lvl = 1'b0;
        run_lvl = 1'b0;
        bl = 0;
        for (int c = 0; c < 1500; c++) begin
            bit btn;
            if (bl > 0) begin
                btn = 1'($urandom_range(0, 1));
                bl--;
            end else begin
                btn = lvl;
            end
            if ($urandom_range(0, 24) == 0) begin
                lvl = !lvl;
                bl = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 59) == 0) run_lvl = !run_lvl;
            cyc(($urandom_range(0, 249) == 0), run_lvl, btn, ($urandom_range(0, 399) == 0));
        end

        // Long run: the TICK_PERIOD=1 instance saturates StepCnt
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (65540) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge Clk);
        #2;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
        end
        checks++;
        if (StepCnt_b !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation: StepCnt=%h, want ffff", StepCnt_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
